// File: rtl/alu_agent_pkg.sv
// Shared types for the ALU agent: opcode encoding plus the tag and response
// records carried through the issuer's FIFOs.
package alu_agent_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } op_type_t;

  typedef struct packed {
    logic [31:0] id;
    bit          div0;
  } alu_tag_t;

  typedef struct packed {
    shortint unsigned result;
    logic [31:0]      id;
    bit               div0;
  } alu_rsp_t;

  function automatic bit is_div0(op_type_t mode, logic [15:0] val2);
    return (mode == DIV) && (val2 == '0);
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with head-of-queue output; push and pop may coincide,
// including on an empty queue and on a full queue that is popping.
module alu_sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = DEPTH[CW-1:0];

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues commands to the ALU, matches in-order results to their transaction
// tags and returns tagged responses; flags lost and spurious ALU results.
module alu_cmd_issuer
  import alu_agent_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_val1,
  input  logic [15:0] cmd_val2,
  input  op_type_t    cmd_mode,
  input  logic [31:0] cmd_id,
  output logic [15:0] alu_val1,
  output logic [15:0] alu_val2,
  output op_type_t    alu_mode,
  output logic        alu_valid_i,
  output logic [31:0] alu_txn_id,
  input  logic        alu_valid_o,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [31:0] rsp_id,
  output logic        rsp_div0,
  output logic        timeout_err,
  output logic        protocol_err
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0]   DEPTH_C = RSP_DEPTH[CW:0];
  localparam logic [IW-1:0] TMO_C   = TIMEOUT[IW-1:0];

  alu_tag_t      tag_in;
  alu_tag_t      tag_head;
  logic          tag_push;
  logic          tag_pop;
  logic          tag_full;
  logic          tag_empty;
  logic [CW-1:0] tag_count;

  alu_rsp_t      rsp_in;
  alu_rsp_t      rsp_head;
  logic          rsp_push;
  logic          rsp_pop;
  logic          rsp_full;
  logic          rsp_empty;
  logic [CW-1:0] rsp_count;

  logic [CW:0]   occupancy;
  logic          accept;
  logic [1:0]    drain_cnt;
  logic          in_drain;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;

  // A slot freed by this cycle's response pop is usable by this cycle's accept.
  assign occupancy = {1'b0, tag_count} + {1'b0, rsp_count};
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign cmd_ready = rst_n && !tag_full && ((occupancy < DEPTH_C) || rsp_pop);
  assign accept    = cmd_valid && cmd_ready;

  assign tag_push = accept;
  assign tag_pop  = alu_valid_o && !tag_empty;
  assign rsp_push = tag_pop && (!rsp_full || rsp_pop);
  assign in_drain = (drain_cnt != '0);

  always_comb begin
    tag_in      = '0;
    tag_in.id   = cmd_id;
    tag_in.div0 = is_div0(cmd_mode, cmd_val2);
  end

  always_comb begin
    rsp_in        = '0;
    rsp_in.result = alu_result;
    rsp_in.id     = tag_head.id;
    rsp_in.div0   = tag_head.div0;
  end

  alu_sync_fifo #(
    .T     (alu_tag_t),
    .DEPTH (RSP_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  alu_sync_fifo #(
    .T     (alu_rsp_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_push),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .head      (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  // Head fields are gated so the outputs read zero whenever nothing is queued.
  assign rsp_result = rsp_valid ? rsp_head.result : '0;
  assign rsp_id     = rsp_valid ? rsp_head.id     : '0;
  assign rsp_div0   = rsp_valid && rsp_head.div0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_valid_i <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_mode    <= ADD;
      alu_txn_id  <= '0;
    end else begin
      alu_valid_i <= accept;
      if (accept) begin
        alu_val1   <= cmd_val1;
        alu_val2   <= cmd_val2;
        alu_mode   <= cmd_mode;
        alu_txn_id <= cmd_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_cnt <= 2'd2;
    end else if (in_drain) begin
      drain_cnt <= drain_cnt - 2'd1;
    end
  end

  always_comb begin
    idle_nxt = idle_cnt;
    if (tag_pop || tag_empty) begin
      idle_nxt = '0;
    end else if (idle_cnt != TMO_C) begin
      idle_nxt = idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt     <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      idle_cnt <= idle_nxt;
      if (idle_nxt == TMO_C) begin
        timeout_err <= 1'b1;
      end
      if (alu_valid_o && tag_empty && !in_drain) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: stub 1-cycle ALU, table of commands with their
// expected responses, and a queue scoreboard checked as responses pop.
module tb_alu_cmd_issuer;
  import alu_agent_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_val1 = '0;
  logic [15:0] cmd_val2 = '0;
  op_type_t    cmd_mode = ADD;
  logic [31:0] cmd_id = '0;
  logic [15:0] alu_val1;
  logic [15:0] alu_val2;
  op_type_t    alu_mode;
  logic        alu_valid_i;
  logic [31:0] alu_txn_id;
  logic        alu_valid_o;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic [31:0] rsp_id;
  logic        rsp_div0;
  logic        timeout_err;
  logic        protocol_err;

  alu_cmd_issuer #(
    .RSP_DEPTH (DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_val1     (cmd_val1),
    .cmd_val2     (cmd_val2),
    .cmd_mode     (cmd_mode),
    .cmd_id       (cmd_id),
    .alu_val1     (alu_val1),
    .alu_val2     (alu_val2),
    .alu_mode     (alu_mode),
    .alu_valid_i  (alu_valid_i),
    .alu_txn_id   (alu_txn_id),
    .alu_valid_o  (alu_valid_o),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_id       (rsp_id),
    .rsp_div0     (rsp_div0),
    .timeout_err  (timeout_err),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub ALU: one-cycle latency, can be silenced, plus a raw strobe injector.
  logic        alu_en = 1'b1;
  logic        inject = 1'b0;
  logic        stub_vo = 1'b0;
  logic [15:0] stub_res = '0;

  function automatic logic [15:0] alu_f(op_type_t m, logic [15:0] a, logic [15:0] b);
    case (m)
      ADD:     return a + b;
      SUB:     return a - b;
      MUL:     return a * b;
      default: return (b == '0) ? 16'hFFFF : a / b;
    endcase
  endfunction

  always @(posedge clk) begin
    stub_vo  <= alu_en && alu_valid_i;
    stub_res <= alu_f(alu_mode, alu_val1, alu_val2);
  end
  assign alu_valid_o = stub_vo | inject;
  assign alu_result  = stub_res;

  typedef struct {
    op_type_t    mode;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [31:0] id;
    logic [15:0] res;
    bit          div0;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [31:0] id;
    bit          div0;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  vec_t tbl [18];
  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   last_acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid === 1'b1 && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id 0x%0h expected no response", rsp_id);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_div0", 32'(rsp_div0), 32'(mon_e.div0));
        if (!mon_e.div0) check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        if (mon_e.chk_lat) check("rsp_latency", cyc - mon_e.acc_cyc, 32'd2);
      end
    end
  end

  task automatic issue(input int idx, input bit to_sb, input bit lat);
    bit acc;
    acc       = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = tbl[idx].mode;
    cmd_val1  = tbl[idx].v1;
    cmd_val2  = tbl[idx].v2;
    cmd_id    = tbl[idx].id;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc          = 1'b1;
        last_acc_cyc = cyc + 1;
        if (to_sb) sb.push_back('{tbl[idx].res, tbl[idx].id, tbl[idx].div0, cyc + 1, lat});
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: vec %0d got cmd_ready=0 expected 1", idx);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  int a5;
  int t0;

  initial begin
    tbl[0]  = '{ADD, 16'd3,     16'd4,   32'h0000000A, 16'd7,     1'b0};
    tbl[1]  = '{ADD, 16'd100,   16'd7,   32'd1,        16'd107,   1'b0};
    tbl[2]  = '{SUB, 16'd100,   16'd7,   32'd2,        16'd93,    1'b0};
    tbl[3]  = '{MUL, 16'd100,   16'd7,   32'd3,        16'd700,   1'b0};
    tbl[4]  = '{DIV, 16'd100,   16'd7,   32'd4,        16'd14,    1'b0};
    tbl[5]  = '{ADD, 16'd1000,  16'd1,   32'h10,       16'd1001,  1'b0};
    tbl[6]  = '{SUB, 16'd5,     16'd9,   32'h11,       16'd65532, 1'b0};
    tbl[7]  = '{MUL, 16'd300,   16'd300, 32'h12,       16'd24464, 1'b0};
    tbl[8]  = '{DIV, 16'hFFFF,  16'd255, 32'h13,       16'd257,   1'b0};
    tbl[9]  = '{ADD, 16'hFFFF,  16'd1,   32'h14,       16'd0,     1'b0};
    tbl[10] = '{MUL, 16'd0,     16'd123, 32'h15,       16'd0,     1'b0};
    tbl[11] = '{DIV, 16'd9,     16'd0,   32'h55,       16'd0,     1'b1};
    tbl[12] = '{ADD, 16'd1,     16'd2,   32'h56,       16'd3,     1'b0};
    tbl[13] = '{ADD, 16'd7,     16'd8,   32'h77,       16'd15,    1'b0};
    tbl[14] = '{ADD, 16'd1,     16'd1,   32'h80,       16'd2,     1'b0};
    tbl[15] = '{ADD, 16'd2,     16'd2,   32'h81,       16'd4,     1'b0};
    tbl[16] = '{ADD, 16'd3,     16'd3,   32'h82,       16'd6,     1'b0};
    tbl[17] = '{SUB, 16'd50,    16'd8,   32'h99,       16'd42,    1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_alu_valid_i", 32'(alu_valid_i), 32'd0);
    check("rst_alu_txn_id", alu_txn_id, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_protocol_err", 32'(protocol_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single ADD: one-cycle issue strobe, 2-cycle response latency
    issue(0, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("issue_strobe", 32'(alu_valid_i), 32'd1);
    check("issue_val1", 32'(alu_val1), 32'd3);
    check("issue_val2", 32'(alu_val2), 32'd4);
    check("issue_mode", 32'(alu_mode), 32'(ADD));
    check("issue_txn_id", alu_txn_id, 32'hA);
    @(negedge clk);
    check("issue_strobe_end", 32'(alu_valid_i), 32'd0);
    wait_drain();

    // Back-to-back all four opcodes
    for (int i = 1; i <= 4; i++) issue(i, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    wait_drain();

    // Backpressure: four credits, then stall until responses drain
    rsp_ready = 1'b0;
    issue(5, 1'b1, 1'b0);
    a5 = last_acc_cyc;
    for (int i = 6; i <= 8; i++) issue(i, 1'b1, 1'b0);
    check("bp_accept_rate", last_acc_cyc - a5, 32'd3);
    cmd_valid = 1'b1;
    cmd_mode  = tbl[9].mode;
    cmd_val1  = tbl[9].v1;
    cmd_val2  = tbl[9].v2;
    cmd_id    = tbl[9].id;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(9, 1'b1, 1'b0);
    issue(10, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_drain();

    // Divide by zero carries the flag, order preserved
    issue(11, 1'b1, 1'b1);
    issue(12, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    wait_drain();

    // Timeout: silent ALU after one issue
    alu_en = 1'b0;
    issue(13, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    t0 = last_acc_cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout_err) break;
    end
    check("timeout_latency", cyc - t0, 32'd16);
    check("timeout_no_proto", 32'(protocol_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    alu_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("timeout_cleared", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    @(negedge clk);
    check("spurious_proto_err", 32'(protocol_err), 32'd1);
    check("spurious_dropped", 32'(rsp_valid), 32'd0);

    // Reset with three ops in flight, stale strobes in the drain window
    @(posedge clk);
    #1 alu_en = 1'b0;
    for (int i = 14; i <= 16; i++) issue(i, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_proto_cleared", 32'(protocol_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    inject = 1'b1;
    repeat (2) @(posedge clk);
    #1 inject = 1'b0;
    alu_en = 1'b1;
    repeat (3) @(negedge clk);
    check("drain_no_proto", 32'(protocol_err), 32'd0);
    check("drain_no_rsp", 32'(rsp_valid), 32'd0);
    check("drain_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(17, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Request-side companion to the ALU datapath: accepts operand/opcode commands on a valid/ready interface, drives the ALU input pins (val1, val2, mode, valid_i, txn_id), and collects the ALU's valid_o/result stream. It returns in-order responses tagged with the originating transaction ID on a second valid/ready interface. It tracks outstanding operations in a tag FIFO, buffers results against response backpressure, flags divide-by-zero, and detects lost or spurious ALU results.

## Interface
- RSP_DEPTH, 4: response buffer and tag FIFO depth; maximum operations in flight plus buffered; power of two, ≥2.
- TIMEOUT, 16: cycles without valid_o while operations are outstanding before timeout_err is raised.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_val1, cmd_val2  in  16 each  unsigned operands.
- cmd_mode  in  op_type_t  ADD/SUB/MUL/DIV.
- cmd_id  in  32  transaction ID.
- alu_val1, alu_val2  out  16 each  to ALU.
- alu_mode  out  op_type_t  to ALU.
- alu_valid_i  out  1  one-cycle issue strobe to ALU.
- alu_txn_id  out  32  ID of the issued op.
- alu_valid_o  in  1  ALU result strobe.
- alu_result  in  16  ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_result  out  16  result.
- rsp_id  out  32  matching cmd_id.
- rsp_div0  out  1  command was DIV with val2 == 0; rsp_result is don't-care.
- timeout_err  out  1  sticky.
- protocol_err  out  1  sticky; valid_o with nothing outstanding.

## Operation
- Reset values: every output 0. Tag FIFO and response FIFO are empty, and the counters are cleared.
- Credit: cmd_ready = rst_n && (tag_count + rsp_count) < RSP_DEPTH. Any result therefore always has a response slot, so there is no backpressure to the ALU.
- Accept (cmd_valid && cmd_ready at edge N):
  - register the operands, mode and id onto the alu_* pins;
  - drive alu_valid_i = 1 for exactly the cycle after edge N;
  - push {cmd_id, div0} into the tag FIFO, where div0 = (mode == DIV && val2 == 0).
- No accept: alu_valid_i = 0. The alu_* data pins hold their last values.
- DIV by zero is still issued to the ALU so that ordering is preserved. Only the flag is carried.
- Capture (alu_valid_o at an edge, tag FIFO non-empty):
  - pop the tag;
  - push {alu_result, tag.id, tag.div0} into the response FIFO.
- The response FIFO head drives the rsp_* outputs. It pops on rsp_valid && rsp_ready.
- Accept, capture and pop may all occur in the same edge. Counts update by the net change, and pushing into a FIFO that the same edge pops is legal.
- Spurious result: alu_valid_o while the tag FIFO is empty.
  - The result is dropped and protocol_err is set.
  - Exception: the first 2 cycles after rst_n deasserts are a drain window. The ALU is not reset, so stale strobes in this window are dropped silently.
- Timeout:
  - the idle counter resets on every capture, and also whenever the tag FIFO is empty;
  - otherwise it increments, saturating at TIMEOUT;
  - reaching TIMEOUT sets timeout_err.
  - Issue and acceptance continue normally after a timeout; the flag is diagnostic only.
- Sticky flags clear only on reset.
- Reset mid-operation discards all in-flight and buffered entries. No responses are emitted for them.

## Timing
- Issue: accept at edge N → alu_valid_i high between edges N and N+1.
- With the 1-cycle ALU: valid_o is high after edge N+1, the capture happens at edge N+2, and rsp_valid is high after edge N+2. Command-to-response latency is 2 cycles.
- Any ALU latency ≥1 cycle is tolerated. Results must return in issue order.
- Throughput is 1 command per cycle when rsp_ready is held high and RSP_DEPTH ≥ 3.
- cmd_ready is a registered-count function and is not combinationally dependent on cmd_valid. It does depend combinationally on the current-cycle pop: a slot freed by rsp_valid && rsp_ready in that cycle is usable in the same cycle.

## Structure
- Add to alu_agent_pkg:
  - alu_tag_t struct {logic [31:0] id; bit div0;}
  - alu_rsp_t struct {shortint unsigned result; logic [31:0] id; bit div0;}
  - op_type_t is reused unchanged from that package.
- One sub-module, alu_sync_fifo #(type T, DEPTH):
  - synchronous active-low reset, push/pop/full/empty/count;
  - simultaneous push and pop are permitted, including when empty;
  - instantiated twice, once for the tag FIFO and once for the response FIFO.
- The top level holds the issue register, credit logic, drain counter and timeout counter.

## Test plan
- Single op: ADD 3+4, id 0xA, rsp_ready=1 → alu_valid_i pulses for 1 cycle; 2 cycles after accept, rsp_valid with result 7 and id 0xA.
- Back-to-back ADD/SUB/MUL/DIV with (100,7), ids 1–4 → responses 107, 93, 700, 14 with ids 1,2,3,4 on consecutive cycles.
- rsp_ready=0, 6 commands offered, RSP_DEPTH=4 → cmd_ready drops after 4 accepts. Raising rsp_ready drains 4 responses, then the remaining 2 are accepted in order.
- DIV 9/0, id 0x55 → response with id 0x55 and rsp_div0=1. A following ADD still returns in order with rsp_div0=0.
- Stub ALU never asserts valid_o after one issue → timeout_err rises 16 cycles after the issue. Forced valid_o with an empty tag FIFO outside the drain window → protocol_err=1.
- Reset asserted with 3 ops in flight, then stale valid_o within 2 cycles of release → no responses and protocol_err=0; new commands behave normally.
